// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD scanner for a common-cathode 7-segment bank.
// Loads are staged in a shadow register and committed only at the frame boundary, so a frame never tears.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic                    blank_lz_i,
  output logic [3:0]              d_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    blank_o,
  output logic                    err_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           prescaler_q, prescaler_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pend_q, pend_d;
  logic                    err_q, err_d;

  logic tc;
  logic fb;
  logic loadInvalid;
  logic [3:0] activeDigit;
  logic lzBlank;
  logic blanked;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      shadow_q    <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    tc = (prescaler_q == PW'(REFRESH_DIV - 1));
    fb = tc && (idx_q == IW'(NUM_DIGITS - 1));

    loadInvalid = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_i[4*k +: 4] > 4'd9) loadInvalid = 1'b1;
    end

    prescaler_d = tc ? '0 : prescaler_q + PW'(1);

    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

    // A load landing on the frame boundary bypasses the shadow so it is not lost for a whole frame.
    shadow_d = load_i ? bcd_i : shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (fb) begin
      pend_d = 1'b0;
      if (load_i)      disp_d = bcd_i;
      else if (pend_q) disp_d = shadow_q;
    end else if (load_i) begin
      pend_d = 1'b1;
    end

    err_d = err_q | (load_i & loadInvalid);
  end

  always_comb begin
    activeDigit = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) activeDigit = disp_q[4*k +: 4];
    end

    // Scan downward so the running flag means "this digit and all above it are zero".
    lzBlank = 1'b0;
    begin : lzScan
      logic allZero;
      allZero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        allZero = allZero && (disp_q[4*k +: 4] == 4'd0);
        if (idx_q == IW'(k)) lzBlank = blank_lz_i && allZero;
      end
    end

    blanked = (activeDigit > 4'd9) || lzBlank;

    d_o     = activeDigit;
    blank_o = blanked;
    an_o    = blanked ? '0 : (NUM_DIGITS'(1) << idx_q);
    err_o   = err_q;
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
`timescale 1ns/1ps
module tb_bcd_display_scanner;

  logic        clk;
  logic        rstN;
  logic        load;
  logic [15:0] bcd;
  logic        blankLz;
  logic [3:0]  dOut;
  logic [3:0]  anOut;
  logic        blankOut;
  logic        errOut;

  int applied;
  int miscompares;
  int cyc;

  typedef struct {
    logic [15:0]     bcd;
    logic            lz;
    logic [3:0][3:0] expD;
    logic [3:0][3:0] expAn;
    logic [3:0]      expBlank;
    logic            expErr;
  } vec_t;

  vec_t vecs[7];
  vec_t hand;

  bcd_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .load_i    (load),
    .bcd_i     (bcd),
    .blank_lz_i(blankLz),
    .d_o       (dOut),
    .an_o      (anOut),
    .blank_o   (blankOut),
    .err_o     (errOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkValue(input string name, input logic [15:0] got, input logic [15:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expD, input logic [3:0] expAn,
                             input logic expBlank, input logic expErr);
    checkValue({name, " d_o"},     {12'd0, dOut},     {12'd0, expD});
    checkValue({name, " an_o"},    {12'd0, anOut},    {12'd0, expAn});
    checkValue({name, " blank_o"}, {15'd0, blankOut}, {15'd0, expBlank});
    checkValue({name, " err_o"},   {15'd0, errOut},   {15'd0, expErr});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic advanceTo(input int pos);
    for (int n = 0; n < 16 && (cyc % 16) != pos; n++) nextCycle();
  endtask

  task automatic applyStimulus(input logic [15:0] value, input int pos);
    advanceTo(pos);
    load = 1'b1;
    bcd  = value;
    nextCycle();
    load = 1'b0;
  endtask

  // Walks one full frame from position 0, checking every cycle of every digit's dwell.
  task automatic checkFrame(input vec_t v, input string tag);
    advanceTo(0);
    for (int p = 0; p < 16; p++) begin
      checkOutput($sformatf("%s dig%0d cyc%0d", tag, p / 4, cyc), v.expD[p / 4], v.expAn[p / 4],
                  v.expBlank[p / 4], v.expErr);
      nextCycle();
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    cyc         = 0;
    rstN        = 1'b0;
    load        = 1'b0;
    bcd         = 16'h0;
    blankLz     = 1'b0;

    vecs[0] = '{16'h1234, 1'b0, 16'h1234, 16'h8421, 4'b0000, 1'b0};
    vecs[1] = '{16'h0047, 1'b1, 16'h0047, 16'h0021, 4'b1100, 1'b0};
    vecs[2] = '{16'h0047, 1'b0, 16'h0047, 16'h8421, 4'b0000, 1'b0};
    vecs[3] = '{16'h0000, 1'b1, 16'h0000, 16'h0001, 4'b1110, 1'b0};
    vecs[4] = '{16'h0500, 1'b1, 16'h0500, 16'h0421, 4'b1000, 1'b0};
    vecs[5] = '{16'h9A01, 1'b0, 16'h9A01, 16'h8021, 4'b0100, 1'b1};
    vecs[6] = '{16'h1111, 1'b0, 16'h1111, 16'h8421, 4'b0000, 1'b1};

    // Reset state and two idle frames.
    repeat (2) @(negedge clk);
    checkOutput("reset", 4'h0, 4'h1, 1'b0, 1'b0);
    rstN = 1'b1;
    cyc  = 0;
    hand = '{16'h0000, 1'b0, 16'h0000, 16'h8421, 4'b0000, 1'b0};
    checkFrame(hand, "idle0");
    checkFrame(hand, "idle1");

    // Table: load mid-frame, old value must persist to the end of the frame, new value shows next frame.
    for (int i = 0; i < 7; i++) begin
      blankLz = vecs[i].lz;
      applyStimulus(vecs[i].bcd, 5);
      checkValue($sformatf("vec%0d err_after_load", i), {15'd0, errOut}, {15'd0, vecs[i].expErr});
      advanceTo(15);
      checkValue($sformatf("vec%0d no_tear", i), {12'd0, dOut},
                 (i == 0) ? 16'h0 : {12'd0, vecs[i - 1].expD[3]});
      checkFrame(vecs[i], $sformatf("vec%0d", i));
    end
    blankLz = 1'b0;

    // Load landing exactly on the frame boundary shows at once.
    applyStimulus(16'h5678, 15);
    hand = '{16'h5678, 1'b0, 16'h5678, 16'h8421, 4'b0000, 1'b1};
    checkFrame(hand, "fbload");

    // Back-to-back loads in one frame: the last one wins, and the value persists.
    applyStimulus(16'h1111, 3);
    applyStimulus(16'h2222, 8);
    advanceTo(15);
    checkValue("b2b no_tear", {12'd0, dOut}, 16'h0005);
    hand = '{16'h2222, 1'b0, 16'h2222, 16'h8421, 4'b0000, 1'b1};
    checkFrame(hand, "b2b");
    checkFrame(hand, "b2b_hold");

    // Reset mid-frame with a load pending: asynchronous clear, pending value discarded.
    applyStimulus(16'h4321, 6);
    advanceTo(9);
    rstN = 1'b0;
    #1;
    checkOutput("async_reset", 4'h0, 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_hold", 4'h0, 4'h1, 1'b0, 1'b0);
    rstN = 1'b1;
    cyc  = 0;
    hand = '{16'h0000, 1'b0, 16'h0000, 16'h8421, 4'b0000, 1'b0};
    checkFrame(hand, "post_reset0");
    checkFrame(hand, "post_reset1");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Multi-digit, time-multiplexed driver for a common-cathode 7-segment display bank.
- Holds an NUM_DIGITS-wide packed BCD value and scans one digit at a time at a divided refresh rate.
- Presents the active digit's 4-bit BCD code on d_o, which feeds the BCD-to-7-segment decoder's d_i directly downstream. Also drives the one-hot digit-enable lines.
- Adds double-buffered, tear-free updates, leading-zero blanking and invalid-digit flagging.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8); digit 0 is least significant
REFRESH_DIV, 1000, clock cycles each digit stays active (>=2)

Ports:
clk_i  input  1  system clock, single clock domain
rst_ni  input  1  asynchronous active-low reset
load_i  input  1  1-cycle strobe: capture bcd_i into shadow register
bcd_i  input  4*NUM_DIGITS  packed BCD value, digit k at bits [4k+3:4k]
blank_lz_i  input  1  1 = blank leading zeros
d_o  output  4  BCD code of active digit, to decoder d_i
an_o  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero when active digit blanked
blank_o  output  1  active digit is blanked
err_o  output  1  sticky: a loaded digit was >9

Behaviour:
- Reset is asynchronous on rst_ni low. It takes effect immediately and holds while low. State after reset:
  - prescaler=0, idx=0, disp=0, shadow=0, pend=0, err_o=0.
  - Resulting outputs: d_o=0, an_o=1 (digit 0), blank_o=0.
- Reset mid-frame discards any pending load.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Terminal count (tc) = prescaler==REFRESH_DIV-1.
- Digit index idx:
  - On tc, idx increments; NUM_DIGITS-1 wraps to 0.
  - Otherwise idx holds.
- Frame boundary (fb) = tc && idx==NUM_DIGITS-1.
- Load and update, one rising edge each:
  - load_i && !fb: shadow<=bcd_i, pend<=1.
  - fb && pend && !load_i: disp<=shadow, pend<=0.
  - fb && load_i (simultaneous): disp<=bcd_i directly, pend<=0. This bypasses the shadow; shadow<=bcd_i as well.
  - Back-to-back loads before fb: the last one wins.
  - The display value therefore changes only on the edge that returns idx to 0. A frame is never torn.
- err_o is set on the edge where load_i=1 and any nibble of bcd_i >9. It clears only on reset.
- Outputs are combinational functions of registered state plus blank_lz_i. There is no combinational path from bcd_i or load_i.
  - d_o = disp[4*idx+3:4*idx].
  - Digit idx is blanked if either condition holds:
    - d_o>9; or
    - blank_lz_i && idx>=1 && digits idx..NUM_DIGITS-1 of disp are all 0.
  - Digit 0 is never LZ-blanked, so value 0 shows a single "0".
  - Blanked: blank_o=1, an_o=0, d_o still driven.
  - Not blanked: blank_o=0, an_o=1<<idx.
- Dwell timing:
  - Each digit is active for exactly REFRESH_DIV cycles.
  - A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Expected size: ~150-250 lines of RTL.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4; frame = 16 cycles):
1. Reset, then idle 32 cycles:
   - d_o=0 throughout.
   - an_o sequence 0001,0010,0100,1000, each held 4 cycles, repeating.
   - blank_o=0, err_o=0.
2. Pulse load_i with bcd_i=16'h1234 at cycle 5 of the frame:
   - disp stays 0 until the fb edge.
   - Next frame shows d_o=4,3,2,1 on an_o=0001,0010,0100,1000.
3. Load 16'h0047 with blank_lz_i=1:
   - Digits 3 and 2: an_o=0000, blank_o=1.
   - Digits 1 and 0 show 4 and 7.
   - Same value with blank_lz_i=0 shows all four digits, 0,0,4,7.
   - Value 16'h0000 with blank_lz_i=1 shows only digit 0 = 0.
4. Assert load_i with 16'h5678 on the fb cycle:
   - Next frame shows 5678 immediately.
   - Separately, two loads 16'h1111 then 16'h2222 within one frame: only 2222 is displayed.
5. Load 16'h9A01:
   - err_o=1 from the next edge and stays high after a later valid load of 16'h1111.
   - Digit 2 (value A) is blanked: blank_o=1, an_o=0.
   - err_o clears only on rst_ni low.
6. Assert rst_ni low mid-frame with a load pending:
   - Outputs return to reset values asynchronously, before the next clock edge.
   - After release, the pending value is never displayed: d_o=0 for a full frame.
